// File: rtl/pcpu_gr_bypass_if.sv
// ID/EX operand bus for the GR bypass unit: source lookups, in-flight results,
// write-back port and the registered operands / stall returned to the pipeline.
interface pcpu_gr_bypass_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int NRD    = 2,
  parameter int NFWD   = 3
);
  logic [NRD-1:0]             rd_en;
  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NFWD-1:0]            fwd_valid;
  logic [NFWD-1:0][AW-1:0]    fwd_addr;
  logic [NFWD-1:0]            fwd_ready;
  logic [NFWD-1:0][DATA_W-1:0] fwd_data;
  logic                       wb_we;
  logic [AW-1:0]              wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic [NRD-1:0][DATA_W-1:0] opnd;
  logic                       opnd_valid;
  logic                       stall;

  modport master (
    output rd_en, rd_addr, fwd_valid, fwd_addr, fwd_ready, fwd_data,
           wb_we, wb_addr, wb_data,
    input  opnd, opnd_valid, stall
  );

  modport slave (
    input  rd_en, rd_addr, fwd_valid, fwd_addr, fwd_ready, fwd_data,
           wb_we, wb_addr, wb_data,
    output opnd, opnd_valid, stall
  );
endinterface

// File: rtl/pcpu_gr_bypass.sv
// General-register file with N-stage operand forwarding, load-use interlock,
// EX operand registers and a saturating stall counter.
module pcpu_gr_bypass #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter int NRD     = 2,
  parameter int NFWD    = 3,
  parameter int ZERO_R0 = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic [CNT_W-1:0]  o_stall_cnt,
  pcpu_gr_bypass_if.slave   bus
);

  logic [NREG-1:0][DATA_W-1:0] r_gr;
  logic [NRD-1:0][DATA_W-1:0]  r_opnd;
  logic                        r_opnd_valid;
  logic [CNT_W-1:0]            r_stall_cnt;

  logic [NRD-1:0][DATA_W-1:0]  w_sel;
  logic [NRD-1:0]              w_haz;
  logic                        w_stall;
  logic                        w_wb_keep;

  // Stages are scanned oldest-first so the youngest match overrides; write-back
  // is the fallback below all forwarding stages.
  always_comb begin
    w_sel = '0;
    w_haz = '0;
    for (int p = 0; p < NRD; p++) begin
      if (bus.rd_en[p] && !((ZERO_R0 != 0) && (bus.rd_addr[p] == '0))) begin
        w_sel[p] = r_gr[bus.rd_addr[p]];
        if (bus.wb_we && (bus.wb_addr == bus.rd_addr[p]))
          w_sel[p] = bus.wb_data;
        for (int s = NFWD - 1; s >= 0; s--) begin
          if (bus.fwd_valid[s] && (bus.fwd_addr[s] == bus.rd_addr[p])) begin
            w_sel[p] = bus.fwd_ready[s] ? bus.fwd_data[s] : '0;
            w_haz[p] = !bus.fwd_ready[s];
          end
        end
      end
    end
  end

  assign w_stall   = i_run && (|w_haz);
  assign w_wb_keep = bus.wb_we && !((ZERO_R0 != 0) && (bus.wb_addr == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gr         <= '0;
      r_opnd       <= '0;
      r_opnd_valid <= 1'b0;
    end else if (i_run) begin
      if (w_wb_keep)
        r_gr[bus.wb_addr] <= bus.wb_data;
      if (i_flush) begin
        r_opnd       <= '0;
        r_opnd_valid <= 1'b0;
      end else if (w_stall) begin
        r_opnd_valid <= 1'b0;
      end else begin
        r_opnd       <= w_sel;
        r_opnd_valid <= 1'b1;
      end
    end
  end

  // Clear is honoured even while the pipeline is frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (i_cnt_clr)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.opnd       = r_opnd;
  assign bus.opnd_valid = r_opnd_valid;
  assign bus.stall      = w_stall;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_dbg_data     = r_gr[i_dbg_addr];

endmodule

// File: tb/tb_pcpu_gr_bypass.sv
// Directed bench: instance A (plain R0, 16-bit counter) and instance B
// (hard-zero R0, 2-bit counter) share identical stimulus.
module tb_pcpu_gr_bypass;
  logic        clock = 1'b0;
  logic        reset;
  logic        run, flush, cnt_clr;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_a, dbg_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  pcpu_gr_bypass_if #(.DATA_W(16), .AW(3), .NRD(2), .NFWD(3)) ifa ();
  pcpu_gr_bypass_if #(.DATA_W(16), .AW(3), .NRD(2), .NFWD(3)) ifb ();

  assign ifb.rd_en     = ifa.rd_en;
  assign ifb.rd_addr   = ifa.rd_addr;
  assign ifb.fwd_valid = ifa.fwd_valid;
  assign ifb.fwd_addr  = ifa.fwd_addr;
  assign ifb.fwd_ready = ifa.fwd_ready;
  assign ifb.fwd_data  = ifa.fwd_data;
  assign ifb.wb_we     = ifa.wb_we;
  assign ifb.wb_addr   = ifa.wb_addr;
  assign ifb.wb_data   = ifa.wb_data;

  pcpu_gr_bypass #(.DATA_W(16), .NREG(8), .NRD(2), .NFWD(3), .ZERO_R0(0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .i_run(run), .i_flush(flush), .i_cnt_clr(cnt_clr),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_a), .o_stall_cnt(cnt_a), .bus(ifa.slave)
  );

  pcpu_gr_bypass #(.DATA_W(16), .NREG(8), .NRD(2), .NFWD(3), .ZERO_R0(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .i_run(run), .i_flush(flush), .i_cnt_clr(cnt_clr),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b), .o_stall_cnt(cnt_b), .bus(ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    run           = 1'b1;
    flush         = 1'b0;
    cnt_clr       = 1'b0;
    ifa.rd_en     = '0;
    ifa.rd_addr   = '0;
    ifa.fwd_valid = '0;
    ifa.fwd_addr  = '0;
    ifa.fwd_ready = '0;
    ifa.fwd_data  = '0;
    ifa.wb_we     = 1'b0;
    ifa.wb_addr   = '0;
    ifa.wb_data   = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    dbg_addr = 3'd3;
    idle();
    #12;
    chk("rst_opnd", ifa.opnd, 32'h0);
    chk("rst_vld", ifa.opnd_valid, 32'h0);
    chk("rst_cnt", cnt_a, 32'h0);
    chk("rst_dbg", dbg_a, 32'h0);
    reset = 1'b0;
    tick();

    // write-through of gr3
    ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd3;
    ifa.wb_we = 1'b1; ifa.wb_addr = 3'd3; ifa.wb_data = 16'h1234;
    #1 chk("wt_stall", ifa.stall, 32'h0);
    tick();
    chk("wt_opnd0", ifa.opnd[0], 32'h1234);
    chk("wt_opnd1_off", ifa.opnd[1], 32'h0);
    chk("wt_vld", ifa.opnd_valid, 32'h1);
    chk("wt_dbg", dbg_a, 32'h1234);
    chk("wt_opnd0_b", ifb.opnd[0], 32'h1234);

    // forwarding priority on port 1; not-ready stage1 is shadowed by stage0
    idle();
    ifa.rd_en = 2'b10; ifa.rd_addr[1] = 3'd2;
    ifa.fwd_valid = 3'b011; ifa.fwd_ready = 3'b001;
    ifa.fwd_addr[0] = 3'd2; ifa.fwd_data[0] = 16'hAAAA;
    ifa.fwd_addr[1] = 3'd2; ifa.fwd_data[1] = 16'hBBBB;
    ifa.wb_we = 1'b1; ifa.wb_addr = 3'd2; ifa.wb_data = 16'hCCCC;
    #1 chk("pri_shadow_stall", ifa.stall, 32'h0);
    tick();
    chk("pri_s0", ifa.opnd[1], 32'h0000AAAA);
    ifa.fwd_valid = 3'b010; ifa.fwd_ready = 3'b010;
    tick();
    chk("pri_s1", ifa.opnd[1], 32'h0000BBBB);
    ifa.fwd_valid = 3'b000;
    tick();
    chk("pri_wb", ifa.opnd[1], 32'h0000CCCC);
    ifa.wb_we = 1'b0;
    tick();
    chk("pri_gr", ifa.opnd[1], 32'h0000CCCC);

    // load-use interlock
    idle();
    ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd3;
    tick();
    chk("lu_pre", ifa.opnd[0], 32'h1234);
    ifa.rd_addr[0] = 3'd5;
    ifa.fwd_valid = 3'b001; ifa.fwd_ready = 3'b000; ifa.fwd_addr[0] = 3'd5;
    #1 chk("lu_stall", ifa.stall, 32'h1);
    tick();
    chk("lu_hold", ifa.opnd[0], 32'h1234);
    chk("lu_bubble", ifa.opnd_valid, 32'h0);
    chk("lu_cnt", cnt_a, 32'h1);
    ifa.fwd_valid = 3'b010; ifa.fwd_ready = 3'b010;
    ifa.fwd_addr[1] = 3'd5; ifa.fwd_data[1] = 16'h0F0F;
    #1 chk("lu_release", ifa.stall, 32'h0);
    tick();
    chk("lu_opnd", ifa.opnd[0], 32'h0F0F);
    chk("lu_vld", ifa.opnd_valid, 32'h1);
    chk("lu_cnt_hold", cnt_a, 32'h1);

    // R0: hard zero on B, ordinary register on A
    idle();
    ifa.wb_we = 1'b1; ifa.wb_addr = 3'd0; ifa.wb_data = 16'hFFFF;
    tick();
    idle();
    dbg_addr = 3'd0;
    ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd0;
    ifa.fwd_valid = 3'b001; ifa.fwd_ready = 3'b000; ifa.fwd_addr[0] = 3'd0;
    #1;
    chk("r0_b_stall", ifb.stall, 32'h0);
    chk("r0_a_stall", ifa.stall, 32'h1);
    tick();
    chk("r0_b_opnd", ifb.opnd[0], 32'h0);
    chk("r0_b_vld", ifb.opnd_valid, 32'h1);
    chk("r0_b_dbg", dbg_b, 32'h0);
    chk("r0_a_dbg", dbg_a, 32'hFFFF);
    chk("r0_a_cnt", cnt_a, 32'h2);
    chk("r0_b_cnt", cnt_b, 32'h1);

    // flush beats stall; stall still counted
    idle();
    dbg_addr = 3'd3;
    ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd5;
    ifa.fwd_valid = 3'b001; ifa.fwd_ready = 3'b000; ifa.fwd_addr[0] = 3'd5;
    flush = 1'b1;
    #1 chk("fl_stall", ifa.stall, 32'h1);
    tick();
    chk("fl_opnd", ifa.opnd, 32'h0);
    chk("fl_vld", ifa.opnd_valid, 32'h0);
    chk("fl_cnt", cnt_a, 32'h3);

    // frozen pipeline: no write, no stall, no count
    flush = 1'b0; run = 1'b0;
    ifa.wb_we = 1'b1; ifa.wb_addr = 3'd3; ifa.wb_data = 16'h5555;
    #1 chk("frz_stall", ifa.stall, 32'h0);
    tick();
    chk("frz_gr", dbg_a, 32'h1234);
    chk("frz_cnt", cnt_a, 32'h3);
    chk("frz_vld", ifa.opnd_valid, 32'h0);

    // saturation on the 2-bit counter
    run = 1'b1; ifa.wb_we = 1'b0;
    repeat (5) tick();
    chk("sat_b", cnt_b, 32'h3);
    chk("sat_a", cnt_a, 32'h8);
    run = 1'b0; cnt_clr = 1'b1;
    tick();
    chk("clr_frozen_a", cnt_a, 32'h0);
    chk("clr_frozen_b", cnt_b, 32'h0);
    run = 1'b1;
    tick();
    chk("clr_wins", cnt_a, 32'h0);

    // async reset between edges
    idle();
    ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd3;
    tick();
    chk("pre_rst_opnd", ifa.opnd[0], 32'h1234);
    ifa.rd_addr[0] = 3'd5;
    ifa.fwd_valid = 3'b001; ifa.fwd_ready = 3'b000; ifa.fwd_addr[0] = 3'd5;
    tick();
    chk("pre_rst_cnt", cnt_a, 32'h1);
    #2;
    idle();
    reset = 1'b1;
    #1;
    chk("ar_opnd", ifa.opnd, 32'h0);
    chk("ar_vld", ifa.opnd_valid, 32'h0);
    chk("ar_cnt", cnt_a, 32'h0);
    chk("ar_dbg", dbg_a, 32'h0);
    chk("ar_stall", ifa.stall, 32'h0);
    #10 reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
